// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame-length helper.
// Used by the transmitter and the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Number of bit periods in one frame: start + data + parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_bits,
                                             input int unsigned stop_bits);
    return 1 + data_bits + parity_bits + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_frame_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period with bit_tick. Held at zero when disabled or on restart.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_tick = enable & (cnt_q == CNT_LAST);

  // Next count: clear on restart or idle, wrap at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || !enable) begin
      cnt_d = '0;
    end else if (bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per frame (start, data LSB first, optional parity,
// 1 or 2 stop bits). Parity is built in only when UART_TX_PARITY_EN is defined.
// Handshake: a word moves when tx_valid and tx_ready are both high at a rising
// clk edge; tx_ready is high exactly while the FSM is idle, and tx_data is
// ignored at every other time.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output uart_state_e          dbg_state
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  // Reject illegal configurations at elaboration.
  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_frame: illegal parameter combination");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif
  logic                 bit_tick;
  logic                 accept;

  assign tx_ready  = (state_q == ST_IDLE);
  assign accept    = tx_valid & tx_ready;
  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign dbg_state = state_q;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .enable  (state_q != ST_IDLE),
    .bit_tick(bit_tick)
  );

  // Frame sequencing: next state, shift register, counters and output bits.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_START;
          shift_d = tx_data;
          idx_d   = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_q == STOP_LAST) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame with the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
